// File: rtl/bram_pkg.sv
// Shared definitions for the single-port BRAM snapshot controller.
// Holds the controller state encoding and the RAM read latency.
package bram_pkg;

    // Cycles from ram_addr (with ram_wr=0) to valid ram_rdata.
    localparam int READ_LATENCY = 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_CAPTURE  = 2'd2,
        ST_PLAYBACK = 2'd3
    } state_t;

endpackage

// File: rtl/bram_rd_skid.sv
// Two-entry FIFO absorbing the RAM read latency during playback.
// Ports: push/push_data in, pop in, flush in, head_data/count out.
module bram_rd_skid #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic [1:0]    count
);

    logic [DW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;

    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/bram_sp_snapshot_ctrl.sv
// Arm/trigger capture into a single-port RAM, then valid/ready replay.
// Ports: arm/abort/cap_len/trig control, in_* stream, out_* stream, ram_*.
module bram_sp_snapshot_ctrl
    import bram_pkg::*;
#(
    parameter int RAM_DATA_WIDTH = 8,
    parameter int RAM_ADDR_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      arm,
    input  logic                      abort,
    input  logic [RAM_ADDR_WIDTH:0]   cap_len,
    input  logic                      trig,
    input  logic                      in_valid,
    input  logic [RAM_DATA_WIDTH-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [RAM_DATA_WIDTH-1:0] out_data,
    output logic                      out_last,
    output logic                      busy,
    output logic                      ram_wr,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic [RAM_DATA_WIDTH-1:0] ram_wdata,
    input  logic [RAM_DATA_WIDTH-1:0] ram_rdata
);

    localparam int CW = RAM_ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH = {1'b1, {RAM_ADDR_WIDTH{1'b0}}};
    // Buffer slots needed to keep one read in flight at full rate.
    localparam int BUF_DEPTH = READ_LATENCY + 1;

    state_t state, state_nx;

    logic [CW-1:0] len;
    logic [CW-1:0] wr_cnt;
    logic [CW-1:0] rd_issue;
    logic [CW-1:0] out_cnt;
    logic          rd_pend;
    logic [1:0]    buf_cnt;
    logic [2:0]    occ;
    logic          wr_en;
    logic          issue;
    logic          pop;
    logic          flush;

    function automatic logic [CW-1:0] sat_len(input logic [CW-1:0] v);
        if (v == '0 || v > DEPTH) begin
            return DEPTH;
        end
        return v;
    endfunction

    assign out_valid = (buf_cnt != 2'd0);
    assign pop       = out_valid & out_ready;
    assign out_last  = out_valid && (out_cnt == len - CW'(1));
    assign busy      = (state != ST_IDLE);
    // Slots already claimed: buffered samples plus the read in flight.
    assign occ       = {1'b0, buf_cnt} + {2'b0, rd_pend};
    assign flush     = (state_nx == ST_IDLE);

    always_comb begin
        state_nx = state;
        wr_en    = 1'b0;
        issue    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (arm && !abort) begin
                    state_nx = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (abort) begin
                    state_nx = ST_IDLE;
                end else if (trig && in_valid) begin
                    wr_en    = 1'b1;
                    state_nx = (len == CW'(1)) ? ST_PLAYBACK
                                               : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (abort) begin
                    state_nx = ST_IDLE;
                end else if (in_valid) begin
                    wr_en = 1'b1;
                    if (wr_cnt + CW'(1) == len) begin
                        state_nx = ST_PLAYBACK;
                    end
                end
            end
            ST_PLAYBACK: begin
                if (abort) begin
                    state_nx = ST_IDLE;
                end else begin
                    // A same-cycle pop frees a slot for the next read.
                    issue = (rd_issue < len) &&
                            (occ < 3'(BUF_DEPTH) + {2'b0, pop});
                    if (pop && out_cnt == len - CW'(1)) begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        ram_wr    = wr_en;
        ram_addr  = '0;
        ram_wdata = '0;
        if (wr_en) begin
            ram_addr  = wr_cnt[RAM_ADDR_WIDTH-1:0];
            ram_wdata = in_data;
        end else if (issue) begin
            ram_addr = rd_issue[RAM_ADDR_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            len      <= '0;
            wr_cnt   <= '0;
            rd_issue <= '0;
            out_cnt  <= '0;
            rd_pend  <= 1'b0;
        end else begin
            state   <= state_nx;
            rd_pend <= issue;
            if (state == ST_IDLE && state_nx == ST_ARMED) begin
                len <= sat_len(cap_len);
            end
            if (state_nx == ST_IDLE) begin
                wr_cnt   <= '0;
                rd_issue <= '0;
                out_cnt  <= '0;
            end else begin
                if (wr_en) begin
                    wr_cnt <= wr_cnt + CW'(1);
                end
                if (issue) begin
                    rd_issue <= rd_issue + CW'(1);
                end
                if (pop) begin
                    out_cnt <= out_cnt + CW'(1);
                end
            end
        end
    end

    bram_rd_skid #(
        .DW(RAM_DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (rd_pend),
        .push_data (ram_rdata),
        .pop       (pop),
        .head_data (out_data),
        .count     (buf_cnt)
    );

endmodule

// File: tb/tb_bram_sp_snapshot_ctrl.sv
// Bench for bram_sp_snapshot_ctrl with an attached behavioural RAM.
// Directed scenarios plus random runs checked against a transaction model.
module tb_bram_sp_snapshot_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          arm;
    logic          abort;
    logic [AW:0]   cap_len;
    logic          trig;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          ram_wr;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    always #5 clk = ~clk;

    bram_sp_snapshot_ctrl #(
        .RAM_DATA_WIDTH(DW),
        .RAM_ADDR_WIDTH(AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .arm       (arm),
        .abort     (abort),
        .cap_len   (cap_len),
        .trig      (trig),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .ram_wr    (ram_wr),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    logic [DW-1:0] ram_mem [DEPTH];

    always @(posedge clk) begin
        if (ram_wr) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h exp=%0h t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    // Model: 0 idle, 1 armed, 2 capturing, 3 playing back.
    int            m_mode = 0;
    int            m_len  = 0;
    int            m_wcnt = 0;
    int            m_pc   = 0;
    bit            m_rhi  = 0;
    bit            m_hold = 0;
    logic [DW-1:0] m_hdata;
    logic [DW-1:0] m_q [$];

    task automatic model_reset();
        m_mode = 0;
        m_wcnt = 0;
        m_hold = 0;
        m_q.delete();
    endtask

    task automatic cyc(input logic a, input logic ab,
                       input logic [AW:0] cl, input logic tg,
                       input logic iv, input logic [DW-1:0] d,
                       input logic rdy);
        int md;
        bit we;
        arm       = a;
        abort     = ab;
        cap_len   = cl;
        trig      = tg;
        in_valid  = iv;
        in_data   = d;
        out_ready = rdy;
        @(negedge clk);
        md = m_mode;
        we = !ab && ((md == 1 && tg && iv) || (md == 2 && iv));
        chk("busy", 32'(busy), 32'(md != 0));
        chk("ram_wr", 32'(ram_wr), 32'(we));
        if (we) begin
            chk("ram_addr", 32'(ram_addr), 32'(m_wcnt));
            chk("ram_wdata", 32'(ram_wdata), 32'(d));
        end
        if (md != 3) begin
            chk("ovalid_off", 32'(out_valid), 32'd0);
        end else begin
            if (m_pc < 2)
                chk("ovalid_early", 32'(out_valid), 32'd0);
            else if (m_pc == 2 || m_rhi)
                chk("ovalid_on", 32'(out_valid), 32'd1);
            if (m_hold) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(m_hdata));
            end
            if (out_valid)
                chk("out_last", 32'(out_last), 32'(m_q.size() == 1));
            m_hold = 0;
            if (!ab && out_valid) begin
                if (!rdy) begin
                    m_hold  = 1;
                    m_hdata = out_data;
                end else if (m_q.size() == 0) begin
                    chk("extra_xfer", 32'(out_valid), 32'd0);
                end else begin
                    chk("out_data", 32'(out_data), 32'(m_q.pop_front()));
                    if (m_q.size() == 0) m_mode = 0;
                end
            end
            if (!rdy) m_rhi = 0;
            m_pc++;
        end
        if (ab && md != 0) begin
            model_reset();
        end else if (md == 0 && a && !ab) begin
            m_mode = 1;
            m_len  = (cl == 0 || cl > DEPTH) ? DEPTH : int'(cl);
            m_wcnt = 0;
            m_q.delete();
        end else if (we) begin
            m_q.push_back(d);
            m_wcnt++;
            if (m_wcnt == m_len) begin
                m_mode = 3;
                m_pc   = 0;
                m_rhi  = 1;
                m_hold = 0;
            end else begin
                m_mode = 2;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    endtask

    // pat: 0 ready always, 1 fixed 1,0,0,1,0,1 pattern, 2 random.
    task automatic drain(input int pat);
        logic [5:0] p;
        logic       rdy;
        p = 6'b101001;
        for (int k = 0; k < 300 && m_mode == 3; k++) begin
            if (pat == 0) rdy = 1'b1;
            else if (pat == 1) rdy = p[k % 6];
            else rdy = 1'($urandom_range(0, 1));
            cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, rdy);
        end
        if (m_mode == 3) chk("drain_timeout", 32'(busy), 32'd0);
        idle_cyc();
    endtask

    task automatic arm_len(input int n);
        cyc(1'b1, 1'b0, (AW+1)'(n), 1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic feed(input logic [DW-1:0] d);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b1, d, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] gap_d [6];
        logic [5:0]    gap_v;
        logic [AW:0]   rcl;
        bit            rall;
        bit            tg_r, iv_r, ab_r, ar_r, rd_r;

        rst = 1'b1;
        arm = 1'b0;
        abort = 1'b0;
        cap_len = '0;
        trig = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ram_wr", 32'(ram_wr), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        rst = 1'b0;
        idle_cyc();

        // Full-depth capture via cap_len=0, sustained playback.
        arm_len(0);
        for (int i = 0; i < 16; i++) feed(DW'(8'h10 + i));
        for (int i = 0; i < 16; i++)
            chk("ram_full", 32'(ram_mem[i]), 32'(8'h10 + i));
        drain(0);

        // Gapped input.
        gap_d = '{8'hA0, 8'h55, 8'hA1, 8'hA2, 8'h66, 8'hA3};
        gap_v = 6'b101101;
        arm_len(4);
        for (int i = 0; i < 6; i++)
            cyc(1'b0, 1'b0, '0, 1'b1, gap_v[i], gap_d[i], 1'b1);
        for (int i = 0; i < 4; i++)
            chk("ram_gap", 32'(ram_mem[i]), 32'(8'hA0 + i));
        drain(0);

        // Backpressure.
        arm_len(6);
        for (int i = 0; i < 6; i++) feed(DW'($urandom));
        drain(1);

        // Trigger gating.
        arm_len(3);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, 8'h77, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 8'h78, 1'b1);
        for (int i = 0; i < 3; i++) feed(DW'(8'hC0 + i));
        drain(0);

        // Abort mid-capture, then a fresh short capture.
        arm_len(8);
        for (int i = 0; i < 3; i++) feed(DW'(8'hD0 + i));
        cyc(1'b1, 1'b1, 5'd2, 1'b1, 1'b1, 8'hEE, 1'b1);
        idle_cyc();
        arm_len(2);
        feed(8'h5A);
        feed(8'h5B);
        drain(0);

        // Single-sample capture.
        arm_len(1);
        feed(8'h3C);
        drain(2);

        // Asynchronous reset mid-playback.
        arm_len(10);
        for (int i = 0; i < 10; i++) feed(DW'($urandom));
        for (int i = 0; i < 4; i++) idle_cyc();
        #3 rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ram_wr", 32'(ram_wr), 32'd0);
        chk("arst_out_last", 32'(out_last), 32'd0);
        model_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        idle_cyc();
        arm_len(5);
        for (int i = 0; i < 5; i++) feed(DW'($urandom));
        drain(0);

        // Random sessions.
        for (int it = 0; it < 40; it++) begin
            rcl  = (AW+1)'($urandom_range(0, 20));
            rall = ($urandom_range(0, 2) == 0);
            cyc(1'b1, 1'b0, rcl, 1'b0, 1'b0, '0, 1'b1);
            for (int k = 0; k < 400 && m_mode != 0; k++) begin
                tg_r = ($urandom_range(0, 3) == 0);
                iv_r = ($urandom_range(0, 2) != 0);
                ab_r = ($urandom_range(0, 59) == 0);
                ar_r = ($urandom_range(0, 7) == 0);
                rd_r = rall ? 1'b1 : 1'($urandom_range(0, 1));
                cyc(ar_r, ab_r, (AW+1)'($urandom_range(0, 20)),
                    tg_r, iv_r, DW'($urandom), rd_r);
            end
            if (m_mode != 0) chk("rand_timeout", 32'(busy), 32'd0);
            idle_cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_sp_snapshot_ctrl.md
Name: bram_sp_snapshot_ctrl

Overview:
- Capture/playback controller that sits directly in front of bram_sync_sp and owns all of its ports.
- On an arm command followed by a trigger, it writes a block of consecutive stream samples into the single-port RAM.
- It then replays that block on a valid/ready output stream.
- Typical use: debug snapshot buffers and packet capture ahead of the readout bus.

Parameters:
- RAM_DATA_WIDTH, 8, sample width; must match the attached bram_sync_sp.
- RAM_ADDR_WIDTH, 4, RAM address width; depth DEPTH = 2**RAM_ADDR_WIDTH.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  reset, asynchronous, active-high; clears all state and outputs.
- arm  in  1  pulse; accepted only in IDLE; latches cap_len.
- abort  in  1  pulse; returns to IDLE from any state.
- cap_len  in  RAM_ADDR_WIDTH+1  samples to capture (1..DEPTH); 0 or >DEPTH means DEPTH.
- trig  in  1  capture trigger, sampled in ARMED.
- in_valid  in  1  input sample strobe (no backpressure).
- in_data  in  RAM_DATA_WIDTH  input sample.
- out_valid  out  1  playback sample valid.
- out_ready  in  1  downstream accept.
- out_data  out  RAM_DATA_WIDTH  playback sample.
- out_last  out  1  high with the final playback sample.
- busy  out  1  high in any state other than IDLE.
- ram_wr  out  1  to bram_sync_sp wr.
- ram_addr  out  RAM_ADDR_WIDTH  to bram_sync_sp addr.
- ram_wdata  out  RAM_DATA_WIDTH  to bram_sync_sp data_in.
- ram_rdata  in  RAM_DATA_WIDTH  from bram_sync_sp data_out; valid one cycle after ram_addr is presented with ram_wr=0.

Behaviour:
- Reset values: state IDLE; out_valid=0, out_last=0, busy=0, ram_wr=0, ram_addr=0, ram_wdata=0, out_data=0. The internal write count, read-issue count and output buffer are cleared.
- State IDLE -> ARMED when arm=1. cap_len is latched as len, saturated to DEPTH.
- State ARMED -> CAPTURE on the first cycle with trig=1 and in_valid=1.
  - That sample is written to address 0 in the same cycle: ram_wr, ram_addr and ram_wdata are combinational from in_valid, in_data and the write count.
- State CAPTURE:
  - Each in_valid=1 cycle writes in_data at the address equal to the write count, then increments the count.
  - Cycles with in_valid=0 write nothing.
  - After the len-th write, go to PLAYBACK. The write count is never allowed to wrap.
- State PLAYBACK: ram_wr=0 throughout.
  - A read of address rd_issue is issued when rd_issue<len and the 2-entry output buffer has room counting in-flight reads.
  - Returned ram_rdata is pushed into the buffer one cycle later.
  - out_valid=1 whenever the buffer is non-empty; the head appears on out_data.
  - A transfer occurs when out_valid and out_ready are both 1. out_last=1 on the transfer of sample len-1.
  - Sustains 1 sample/cycle with out_ready held high. First out_valid rises 2 cycles after entering PLAYBACK.
  - After the last transfer -> IDLE.
- abort in ARMED, CAPTURE or PLAYBACK -> IDLE next cycle. The buffer is flushed, out_valid drops, and RAM contents are not cleared.
- abort and arm in the same cycle: abort wins.
- arm outside IDLE is ignored. trig outside ARMED is ignored.
- Reset mid-CAPTURE or mid-PLAYBACK: immediate asynchronous return to IDLE with all outputs at reset values.
- len=1 case: one write, then one playback sample with out_last=1.
- Address arithmetic is RAM_ADDR_WIDTH bits. Counters are RAM_ADDR_WIDTH+1 bits so that a count equal to DEPTH is representable.

Decomposition:
- Shared package bram_pkg holds:
  - state encodings ST_IDLE, ST_ARMED, ST_CAPTURE, ST_PLAYBACK (2-bit);
  - the READ_LATENCY=1 constant shared with bram_sync_sp.
- One natural sub-module: bram_rd_skid, a 2-entry valid/ready buffer absorbing the 1-cycle RAM read latency. Ports: push, push_data, pop (valid&ready), head_data, count.

Test Plan:
- Full capture: arm with cap_len=0; trig with in_valid every cycle, in_data=0x10..0x1F -> 16 writes to addr 0..15. Playback with out_ready=1 gives 0x10..0x1F on consecutive cycles, out_last on 0x1F, then busy=0.
- Gapped input: cap_len=4, in_valid pattern 1,0,1,1,0,1 with data A0,xx,A1,A2,xx,A3 -> RAM addr0..3 = A0..A3. Playback gives A0..A3 in order.
- Backpressure: cap_len=6, out_ready toggling 1,0,0,1,0,1... -> no sample lost or duplicated. out_data stays stable while out_valid=1 and out_ready=0.
- Trigger gating: arm, then trig=1 with in_valid=0, then trig=0 with in_valid=1 -> remains ARMED with no write. Trig and in_valid together then starts capture.
- Abort: abort after 3 of 8 captured samples -> IDLE next cycle with busy=0. A new arm with cap_len=2 captures and plays back exactly 2 fresh samples.
- Async reset: assert rst mid-PLAYBACK between clock edges -> out_valid=0, busy=0, ram_wr=0 immediately, and the next arm behaves normally.
